// File: rtl/ula_datapath.sv
// Multi-cycle execution datapath: register file with hardwired r0, register/immediate
// SrcB select, 8-operation ULA with zero/overflow flags, sequenced by a start/busy/done FSM.
module ula_datapath #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int IMM_VAL = 7
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [2:0]        alu_ctrl,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic              src_b_imm,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [1:0]        dbg_state
);

  localparam int                NREGS = 2 ** ADDR_W;
  localparam int                MSB   = DATA_W - 1;
  localparam logic [DATA_W-1:0] IMM_B = DATA_W'(IMM_VAL);

  // Handshake: start/load_en are sampled only while IDLE; busy covers READ..WRITE,
  // done is a single-cycle pulse during WRITE. Requests seen while busy are dropped.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [2:0]        ctrl_q;
  logic [ADDR_W-1:0] ra1_q, ra2_q, wa3_q;
  logic              imm_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q, ovf_q, busy_q, done_q;

  logic [DATA_W-1:0] sum, diff;
  logic [DATA_W-1:0] alu_res_d;
  logic              alu_ovf_d;

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  always_comb begin
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    case (ctrl_q)
      3'b000: alu_res_d = a_q & b_q;
      3'b001: alu_res_d = a_q | b_q;
      3'b010: begin
        alu_res_d = sum;
        alu_ovf_d = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      3'b011: alu_res_d = a_q ^ b_q;
      3'b100: alu_res_d = ~(a_q | b_q);
      3'b101: alu_res_d = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
      3'b110: begin
        alu_res_d = diff;
        alu_ovf_d = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      3'b111: alu_res_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_res_d = '0;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      ctrl_q   <= '0;
      ra1_q    <= '0;
      ra2_q    <= '0;
      wa3_q    <= '0;
      imm_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A same-cycle load lands on this edge, so READ already sees it.
          if (load_en && (load_addr != '0)) rf_q[load_addr] <= load_data;
          if (start) begin
            ctrl_q  <= alu_ctrl;
            ra1_q   <= ra1;
            ra2_q   <= ra2;
            wa3_q   <= wa3;
            imm_q   <= src_b_imm;
            busy_q  <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          a_q     <= rf_q[ra1_q];
          b_q     <= imm_q ? IMM_B : rf_q[ra2_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= alu_res_d;
          zero_q   <= (alu_res_d == '0);
          ovf_q    <= alu_ovf_d;
          done_q   <= 1'b1;
          state_q  <= S_WRITE;
        end
        S_WRITE: begin
          if (wa3_q != '0) rf_q[wa3_q] <= result_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dbg_data  = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];
  assign dbg_state = state_q;

endmodule

// File: doc/ula_datapath.md
# ula_datapath

Parametrised multi-cycle execution datapath for the MIPS CPU track. It succeeds the single-cycle register-file/MUX/ULA arrangement with one sequenced unit. The unit contains:
- a generic register file with a hardwired-zero register 0;
- a register/immediate source-B select;
- an extended 8-operation ULA with zero and overflow flags;
- a start/busy/done handshake that reads operands, executes and writes back.

It sits between the board-level switch/key front end, or a future control unit, and the display/LCD debug path.

## Interface
- DATA_W, 8, datapath and register width (≥4)
- ADDR_W, 3, register address width; file holds 2^ADDR_W registers
- IMM_VAL, 7, constant used as SrcB when src_b_imm=1 (truncated to DATA_W)

Ports:
- iCLK  in  1  single clock, all state on rising edge
- iRST_N  in  1  asynchronous, active-low reset
- load_en  in  1  direct register write request (accepted only in IDLE)
- load_addr  in  ADDR_W  direct write address
- load_data  in  DATA_W  direct write data
- start  in  1  operation request (accepted only in IDLE)
- alu_ctrl  in  3  ULAControl: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLTU, 110 SUB, 111 SLT
- ra1, ra2, wa3  in  ADDR_W  SrcA address, SrcB register address, writeback address
- src_b_imm  in  1  0: SrcB=rf[ra2]; 1: SrcB=IMM_VAL
- busy  out  1  high in READ/EXEC/WRITE
- done  out  1  one-cycle pulse in WRITE
- result  out  DATA_W  registered ULAResult of last operation
- zero  out  1  registered, result==0
- ovf  out  1  registered signed overflow (ADD/SUB only, else 0)
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  combinational rf[dbg_addr]

## Operation
- FSM states: IDLE → READ → EXEC → WRITE → IDLE.
- IDLE:
  - start=1 → READ; capture alu_ctrl, ra1, ra2, wa3 and src_b_imm.
  - load_en=1 → rf[load_addr]←load_data. If load_addr=0 there is no effect.
- READ: latch A=rf[ra1]. Latch B=src_b_imm ? IMM_VAL : rf[ra2].
- EXEC: compute f(A,B); register result, zero and ovf.
- WRITE:
  - rf[wa3]←result unless wa3=0; done=1.
  - Return to IDLE next cycle.
- Register 0 always reads 0. Writes to it are dropped from both load and writeback.
- Arithmetic: ADD/SUB are mod 2^DATA_W.
  - ovf for ADD = operands same sign and result sign differs.
  - ovf for SUB = operand signs differ and result sign differs from A.
- SLT = signed A<B. SLTU = unsigned A<B. Both return 1 or 0 zero-extended.
- NOR = ~(A|B).
- start and load_en while busy: ignored, not queued.
- start and load_en together in IDLE: both accepted. The load lands on that edge, and READ observes the new value.
- Reset (any time, including mid-operation):
  - all registers, result, zero and ovf become 0;
  - busy=0, done=0, FSM=IDLE;
  - a pending writeback is abandoned.

## Timing
- Start sampled at edge T0. busy=1 from T0 through WRITE. done=1 during cycle T2–T3. Writeback visible on dbg_data after edge T3. busy=0 after T3.
- Latency: 3 cycles start→done. Throughput: one operation per 4 cycles; start is accepted again in the cycle after done.
- result/zero/ovf update at the end of EXEC and hold until the next EXEC or reset.
- dbg_data is purely combinational from the file. There is no read-during-write bypass: it shows the old value until the edge.

## Test plan
- Reset, then load r1=0x05, r2=0x03; ADD ra1=1 ra2=2 wa3=3 → done 3 cycles after start, result=0x08, rf[3]=0x08, zero=0, ovf=0.
- SUB ra1=1 ra2=1 wa3=4 → result=0x00, zero=1, rf[4]=0x00. Then load r5=0x7F, r6=0x01; ADD → result=0x80, ovf=1.
- Load r2=0x03; src_b_imm=1 SUB ra1=2 wa3=7 → result=0xFC. SLT ra1=7 imm → result=0x01. SLTU ra1=7 imm → result=0x00.
- Load r0=0xAA and ADD with wa3=0 → dbg_data at addr 0 stays 0x00. start/load_en pulsed while busy → no state change, no extra done.
- Assert iRST_N low during EXEC of an op targeting r3 → busy=0, done never pulses, rf[3]=0, result=0 after release.
- Same-cycle load r1=0x10 with start ADD ra1=1 ra2=2(=0x03) → result=0x13.
